// File: rtl/mips_cpu_regfile_sequencer.sv
// mips_cpu_regfile_sequencer: reads rs/rt from the register file, hands operands to execute, arbitrates writeback.
module mips_cpu_regfile_sequencer #(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_w_en,
  output logic [4:0]        rf_w_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic [4:0]        rf_r_addr_a,
  output logic [4:0]        rf_r_addr_b,
  input  logic [DATA_W-1:0] rf_r_data_a,
  input  logic [DATA_W-1:0] rf_r_data_b
);
  typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_t;
  state_t            r_state, w_next;
  logic [4:0]        r_rs, r_rt;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic              r_op_valid;
  logic              w_instr_fire, w_byp, w_hit_a, w_hit_b;
  logic              w_unused;
  assign w_unused    = ^{instr[31:26], instr[15:0]};
  assign op_valid    = r_op_valid;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign rf_w_addr   = wb_addr;
  assign rf_d_in     = wb_data;
  assign rf_r_addr_a = r_rs;
  assign rf_r_addr_b = r_rt;
  // RD is the only cycle the read port needs write-enable low, so writeback stalls there
  always_comb begin
    instr_ready  = !reset && r_state == IDLE && !wb_valid;
    wb_ready     = !reset && r_state != RD;
    w_instr_fire = instr_valid && instr_ready;
    rf_w_en      = wb_valid && wb_ready && wb_addr != 5'd0;
    w_byp        = BYPASS_EN && rf_w_en && (r_state == CAP || (r_state == HOLD && !op_ready));
    w_hit_a      = w_byp && wb_addr == r_rs;
    w_hit_b      = w_byp && wb_addr == r_rt;
    w_next       = (r_state == IDLE && w_instr_fire) ? RD :
                   (r_state == RD)                   ? CAP :
                   (r_state == CAP)                  ? HOLD :
                   (r_state == HOLD && op_ready)     ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rs       <= '0;
      r_rt       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_op_valid <= w_next == HOLD;
      if (w_instr_fire) {r_rs, r_rt} <= {instr[25:21], instr[20:16]};
      if (r_state == CAP || w_hit_a) r_op_a <= w_hit_a ? wb_data : rf_r_data_a;
      if (r_state == CAP || w_hit_b) r_op_b <= w_hit_b ? wb_data : rf_r_data_b;
    end
  end
endmodule

// File: tb/tb_mips_cpu_regfile_sequencer.sv
// tb_mips_cpu_regfile_sequencer: bypass and no-bypass instances share stimulus, each with its own register-file model.
module tb_mips_cpu_regfile_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        op_ready = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        rf_clr = 1'b1;
  logic [1:0]  instr_ready_v, op_valid_v, wb_ready_v, rf_w_en_v;
  logic [31:0] op_a_v [2];
  logic [31:0] op_b_v [2];
  logic [31:0] d_in_v [2];
  logic [31:0] rda_v [2];
  logic [31:0] rdb_v [2];
  logic [4:0]  wa_v [2];
  logic [4:0]  raa_v [2];
  logic [4:0]  rab_v [2];
  logic [31:0] mem [2][32];
  logic [63:0] sb [$];
  logic [63:0] e;
  int          n_cmp = 0, n_bad = 0, hs = 0, lat;
  always #5 clk = ~clk;
  mips_cpu_regfile_sequencer #(.DATA_W(32), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready_v[0]), .instr(instr),
    .op_valid(op_valid_v[0]), .op_ready(op_ready), .op_a(op_a_v[0]), .op_b(op_b_v[0]),
    .wb_valid(wb_valid), .wb_ready(wb_ready_v[0]), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_w_en(rf_w_en_v[0]), .rf_w_addr(wa_v[0]), .rf_d_in(d_in_v[0]),
    .rf_r_addr_a(raa_v[0]), .rf_r_addr_b(rab_v[0]), .rf_r_data_a(rda_v[0]), .rf_r_data_b(rdb_v[0]));
  mips_cpu_regfile_sequencer #(.DATA_W(32), .BYPASS_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready_v[1]), .instr(instr),
    .op_valid(op_valid_v[1]), .op_ready(op_ready), .op_a(op_a_v[1]), .op_b(op_b_v[1]),
    .wb_valid(wb_valid), .wb_ready(wb_ready_v[1]), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_w_en(rf_w_en_v[1]), .rf_w_addr(wa_v[1]), .rf_d_in(d_in_v[1]),
    .rf_r_addr_a(raa_v[1]), .rf_r_addr_b(rab_v[1]), .rf_r_data_a(rda_v[1]), .rf_r_data_b(rdb_v[1]));
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (rf_clr) begin
        for (int j = 0; j < 32; j++) mem[i][j] <= '0;
        rda_v[i] <= '0;
        rdb_v[i] <= '0;
      end else if (rf_w_en_v[i]) mem[i][wa_v[i]] <= d_in_v[i];
      else begin
        rda_v[i] <= mem[i][raa_v[i]];
        rdb_v[i] <= mem[i][rab_v[i]];
      end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && op_valid_v[0] && op_ready) begin
      hs++;
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("op_a", op_a_v[0], e[63:32]);
        chk("op_b", op_b_v[0], e[31:0]);
      end
    end
  task automatic start(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] ea, input logic [31:0] eb);
    bit ok = 0;
    instr_valid = 1'b1;
    instr = {6'd0, rs, rt, 16'h1234};
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = instr_ready_v[0];
      if (!ok) @(posedge clk);
    end
    chk("instr_accept", {31'd0, ok}, 32'd1);
    sb.push_back({ea, eb});
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask
  task automatic wait_ov(output int l);
    l = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rd_wen", {31'd0, rf_w_en_v[0]}, 32'd0);
        chk("rd_wbr", {31'd0, wb_ready_v[0]}, 32'd0);
      end
      if (op_valid_v[0]) break;
      @(posedge clk);
      l++;
    end
  endtask
  task automatic wb_drive(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    instr_valid = 1'b1;
    instr = {6'd0, 5'd8, 5'd9, 16'd0};
    wb_drive(5'd5, 32'hCAFE0005);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", {31'd0, instr_ready_v[0]}, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready_v[0]}, 32'd0);
    chk("rst_wen", {31'd0, rf_w_en_v[0]}, 32'd0);
    chk("rst_op_valid", {31'd0, op_valid_v[0]}, 32'd0);
    chk("rst_op_a", op_a_v[0], 32'd0);
    chk("rst_op_b", op_b_v[0], 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    rf_clr = 1'b0;
    instr_valid = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("idle_wb_ready", {31'd0, wb_ready_v[0]}, 32'd1);
    chk("idle_instr_ready", {31'd0, instr_ready_v[0]}, 32'd1);
    tick();
    wb_drive(5'd8, 32'h11111111);
    tick();
    wb_drive(5'd9, 32'h22222222);
    tick();
    wb_valid = 1'b0;
    op_ready = 1'b1;
    start(5'd8, 5'd9, 32'h11111111, 32'h22222222);
    wait_ov(lat);
    chk("latency", lat, 32'd3);
    tick();
    wb_drive(5'd8, 32'hAAAA0000);
    instr_valid = 1'b1;
    instr = {6'd0, 5'd8, 5'd9, 16'd0};
    @(negedge clk);
    chk("prio_instr_ready", {31'd0, instr_ready_v[0]}, 32'd0);
    chk("prio_wen", {31'd0, rf_w_en_v[0]}, 32'd1);
    tick();
    wb_valid = 1'b0;
    start(5'd8, 5'd9, 32'hAAAA0000, 32'h22222222);
    wait_ov(lat);
    chk("latency2", lat, 32'd3);
    tick();
    op_ready = 1'b0;
    start(5'd8, 5'd9, 32'hAAAA0000, 32'hDEADBEEF);
    wait_ov(lat);
    chk("hold_b_before", op_b_v[0], 32'h22222222);
    tick();
    wb_drive(5'd9, 32'hDEADBEEF);
    @(negedge clk);
    chk("hold_wen", {31'd0, rf_w_en_v[0]}, 32'd1);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("hold_valid", {31'd0, op_valid_v[0]}, 32'd1);
    chk("hold_byp_b", op_b_v[0], 32'hDEADBEEF);
    chk("nobyp_b", op_b_v[1], 32'h22222222);
    chk("nobyp_valid", {31'd0, op_valid_v[1]}, 32'd1);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    start(5'd9, 5'd8, 32'hDEADBEEF, 32'hAAAA0000);
    wait_ov(lat);
    tick();
    op_ready = 1'b1;
    wb_drive(5'd9, 32'h12345678);
    @(negedge clk);
    chk("simul_wen", {31'd0, rf_w_en_v[0]}, 32'd1);
    tick();
    wb_valid = 1'b0;
    wb_drive(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("r0_wb_ready", {31'd0, wb_ready_v[0]}, 32'd1);
    chk("r0_wen", {31'd0, rf_w_en_v[0]}, 32'd0);
    tick();
    wb_valid = 1'b0;
    start(5'd0, 5'd9, 32'd0, 32'h12345678);
    wait_ov(lat);
    tick();
    start(5'd8, 5'd9, 32'h55555555, 32'h12345678);
    wb_drive(5'd8, 32'h55555555);
    fork
      wait_ov(lat);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("cap_wb_ready", {31'd0, wb_ready_v[0]}, 32'd1);
        chk("cap_wen", {31'd0, rf_w_en_v[0]}, 32'd1);
        tick();
        wb_valid = 1'b0;
      end
    join
    chk("latency_rdwb", lat, 32'd3);
    tick();
    instr_valid = 1'b1;
    instr = {6'd0, 5'd8, 5'd9, 16'd0};
    @(negedge clk);
    chk("abort_accept", {31'd0, instr_ready_v[0]}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_instr_ready", {31'd0, instr_ready_v[0]}, 32'd0);
    chk("abort_wb_ready", {31'd0, wb_ready_v[0]}, 32'd0);
    tick();
    reset = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_op_valid", {31'd0, op_valid_v[0]}, 32'd0);
    chk("abort_op_a", op_a_v[0], 32'd0);
    chk("abort_op_b", op_b_v[0], 32'd0);
    chk("abort_idle", {31'd0, instr_ready_v[0]}, 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("hs_total", hs, 32'd6);
    chk("sb_left", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_cpu_regfile_sequencer.md
Name: mips_cpu_regfile_sequencer

Overview:
- Initiator side of the register-file interface. Drives the file's write-enable, write address, write data and the two read addresses, and consumes the two read-data outputs.
- Takes decoded instruction words from fetch, issues rs/rt reads and captures the operands. Presents the operands to execute with a valid/ready handshake.
- Arbitrates writeback requests onto the single write port. The register file updates its read data only in cycles with write-enable low, so reads and writes must never overlap.

Parameters:
- DATA_W, 32, register data width
- BYPASS_EN, 1, when 1 a write to rs/rt updates operands already captured

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  fetch offers an instruction
- instr_ready  output  1  sequencer accepts the instruction
- instr  input  32  instruction word; rs = [25:21], rt = [20:16]
- op_valid  output  1  operands valid
- op_ready  input  1  execute accepts the operands
- op_a  output  DATA_W  value of rs
- op_b  output  DATA_W  value of rt
- wb_valid  input  1  writeback request
- wb_ready  output  1  writeback accepted this cycle
- wb_addr  input  5  destination register
- wb_data  input  DATA_W  write data
- rf_w_en  output  1  register-file write enable
- rf_w_addr  output  5  register-file write address
- rf_d_in  output  DATA_W  register-file write data
- rf_r_addr_a  output  5  read address A (rs)
- rf_r_addr_b  output  5  read address B (rt)
- rf_r_data_a  input  DATA_W  read data A, valid one cycle after its address with rf_w_en=0
- rf_r_data_b  input  DATA_W  read data B, same timing as A

Behaviour:
- Reset: state IDLE; op_valid=0; op_a=op_b=0; rs/rt latches=0; instr_ready=0; wb_ready=0; rf_w_en=0. While reset=1, both handshakes are refused. Reset mid-operation discards the in-flight instruction and any writeback presented that cycle.
- FSM states: IDLE, RD, CAP, HOLD.
- IDLE:
  - wb_ready = 1.
  - instr_ready = !wb_valid, so writeback has priority.
  - On an instr handshake, latch rs/rt and go to RD.
- RD:
  - rf_r_addr_a/b = latched rs/rt.
  - wb_ready = 0 and rf_w_en = 0 (forced).
  - Unconditionally go to CAP.
- CAP:
  - rf_r_data_a/b are valid this cycle.
  - wb_ready = 1.
  - On the edge, op_a/op_b <= rf data, with bypass applied (see below). Go to HOLD.
- HOLD:
  - op_valid = 1 (registered, asserted on entry); operands held stable.
  - wb_ready = 1.
  - On op_ready, clear op_valid and go to IDLE.
  - instr_ready = 0 in every state except IDLE.
- Latency: instr handshake at edge N gives op_valid high in the cycle after edge N+2 (three cycles), assuming no stall.
- Write path is combinational:
  - rf_w_en = wb_valid & wb_ready & (wb_addr != 0).
  - rf_w_addr = wb_addr; rf_d_in = wb_data.
  - The register file updates on the same edge.
  - A writeback to r0 completes the handshake but never asserts rf_w_en.
- Bypass (BYPASS_EN=1), in CAP or HOLD:
  - A completing write with wb_addr != 0 and wb_addr == rs loads wb_data into op_a; same rule for rt into op_b.
  - If rs == rt, both operands are updated.
  - In CAP, the bypass takes precedence over rf data.
  - With BYPASS_EN=0, no update; execute resolves the hazard.
- Simultaneous events:
  - HOLD with op_ready and a write hitting rs in the same cycle: the handshake completes with the old operands, and the write still reaches the file.
  - IDLE with wb_valid and instr_valid: write this cycle, instruction next eligible cycle.
- No instruction queuing: at most one in flight.

Test Plan:
- Reset, then preload r8=0x11111111 and r9=0x22222222 via wb. Send instr with rs=8, rt=9, op_ready=1 -> op_valid rises exactly 3 cycles after the handshake; op_a=0x11111111, op_b=0x22222222; rf_w_en=0 during RD.
- In IDLE, present wb_valid (addr 8, 0xAAAA0000) and instr_valid together -> write accepted first; instr_ready=0 that cycle; instruction accepted the next cycle and op_a=0xAAAA0000.
- Hold op_ready=0 in HOLD and write r9=0xDEADBEEF -> op_b changes to 0xDEADBEEF while op_valid stays 1. Repeat with BYPASS_EN=0 -> op_b unchanged.
- Writeback with wb_addr=0 and data 0xFFFFFFFF -> wb_ready=1, rf_w_en=0; a later read of r0 returns 0.
- Present wb_valid during RD -> wb_ready=0 and rf_w_en=0; the write is accepted in CAP, and bypass into op_a occurs if it targets rs.
- Assert reset in CAP -> next cycle IDLE, op_valid=0, op_a=op_b=0; no operand handshake ever occurs for the aborted instruction.
